alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the ALU (2..8).
REQ-002 Parameter WIDTH, default 8: operand and result width.
REQ-003 Parameter OPW, default 3: ALU opcode width.
REQ-004 Parameter ALU_LAT, default 1: clock cycles from ALU operand drive to valid alu_r (1..7).
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NREQ  per-requester operation request.
REQ-008 req_a  in  NREQ*WIDTH  operand A, slice i belongs to requester i.
REQ-009 req_b  in  NREQ*WIDTH  operand B, slice i.
REQ-010 req_op  in  NREQ*OPW  opcode, slice i.
REQ-011 req_ready  out  NREQ  one-hot acceptance strobe.
REQ-012 alu_a, alu_b  out  WIDTH  operands to the shared ALU (in_a, in_b).
REQ-013 alu_op  out  OPW  opcode to the ALU (in_op).
REQ-014 alu_r  in  WIDTH  ALU result (out_r).
REQ-015 rsp_valid  out  1  result available.
REQ-016 rsp_data  out  WIDTH  result value.
REQ-017 rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_data.
REQ-018 rsp_ready  in  1  consumer accepts the response.

Function
REQ-019 FSM states: IDLE, EXEC, RESP; exactly one operation in flight.
REQ-020 IDLE: if any req_valid is high, the granted index g is the first requester with req_valid high, searching from ptr+1 upward with wrap-around modulo NREQ; req_ready[g] is high combinationally in the same cycle; all other req_ready bits are low.
REQ-021 A transfer occurs when req_valid[g] and req_ready[g] are both high; at that edge req_a/req_b/req_op slice g and g are captured, ptr<=g, and the state becomes EXEC.
REQ-022 req_ready is low in EXEC and RESP.
REQ-023 alu_a/alu_b/alu_op hold the captured operands from EXEC entry until the next capture; they read 0 after reset.
REQ-024 EXEC: a down-counter loaded with ALU_LAT at capture counts down; when it reaches 0, alu_r is registered into rsp_data, rsp_id<=g, and the state becomes RESP.
REQ-025 Capture-to-rsp_valid latency is ALU_LAT+1 cycles.
REQ-026 RESP: rsp_valid is high; rsp_data and rsp_id are stable until rsp_valid&rsp_ready.
REQ-027 On rsp_valid&rsp_ready the state returns to IDLE; a new grant is possible from the next cycle (minimum 3+ALU_LAT cycles per operation).
REQ-028 No request is ever dropped: a requester holding req_valid is granted within NREQ operations (round-robin fairness).
REQ-029 Requests that deassert req_valid before they are granted are ignored; there is no internal request queue.
REQ-030 rsp_ready held high continuously gives back-to-back operations with no extra stall.

Reset
REQ-031 rst high at any edge, including mid-EXEC or mid-RESP, forces IDLE, ptr<=NREQ-1 (so requester 0 has first priority), rsp_valid<=0, rsp_data<=0, rsp_id<=0, and counter<=0; any in-flight operation is discarded.
REQ-032 While rst is high, req_ready is all-zero.

Structure
REQ-033 The FSM state encoding and the default WIDTH/OPW constants reside in the shared processor package used by the ALU.
REQ-034 The round-robin priority picker (request vector plus ptr in, one-hot grant out, purely combinational) is one sub-module, rr_picker.

Verification (ALU model: op 0 = ADD, op 1 = SUB; ALU_LAT=1)
REQ-035 Single request: req 0 with a=0x79, b=0x65, op=0 -> req_ready[0] in the same cycle; rsp_valid 2 cycles later with rsp_data=0xDE, rsp_id=0.
REQ-036 All four requesters held valid after reset, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are held stable; no req_ready asserted; accepted on the first cycle rsp_ready=1.
REQ-038 Wrap: ptr=3, req_valid=4'b0101 -> grant 0; then grant 2.
REQ-039 Reset mid-EXEC (req 2, a=0x79, b=0x65, op=1) -> no response; next request from req 1 alone is granted and returns its own result.
REQ-040 Arithmetic wrap is passed through unchanged: a=0xFF, b=0x01, op=0 -> rsp_data=0x00.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the processor ALU and its front-end arbiter.
//   ALU_WIDTH   default operand/result width
//   ALU_OPW     default opcode width
//   arb_state_e arbiter FSM encoding
package alu_arbiter_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int ALU_OPW   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin priority picker, purely combinational.
//   req    request vector, one bit per requester
//   ptr    index of the most recently granted requester
//   grant  one-hot grant: first set req bit searching from ptr+1 upward,
//          wrapping modulo NREQ; all-zero when req is empty
module rr_picker #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         grant
);

   localparam int IW = $clog2(NREQ);

   always_comb begin
      logic         found;
      logic [IW-1:0] idx;
      grant = '0;
      found = 1'b0;
      idx   = '0;
      // i runs 1..NREQ so the last candidate checked is ptr itself
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbiter sharing one pipelined ALU among NREQ requesters, one operation
// in flight at a time, round-robin fair.
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (ready one-hot)
//   req_a/req_b/req_op       packed per-requester operands, slice i = req i
//   alu_a/alu_b/alu_op       operands driven to the shared ALU
//   alu_r                    ALU result, valid ALU_LAT cycles after drive
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/rsp_id          result and owning requester index
//
// state | meaning
// IDLE  | waiting for any req_valid; grant offered combinationally
// EXEC  | operands on the ALU, latency counter running down
// RESP  | result held until rsp_ready
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = ALU_WIDTH,
   parameter int OPW     = ALU_OPW,
   parameter int ALU_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ*OPW-1:0]     req_op,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        alu_a,
   output logic [WIDTH-1:0]        alu_b,
   output logic [OPW-1:0]          alu_op,
   input  logic [WIDTH-1:0]        alu_r,
   output logic                    rsp_valid,
   output logic [WIDTH-1:0]        rsp_data,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   input  logic                    rsp_ready
);

   localparam int IW = $clog2(NREQ);

   arb_state_e     state, state_nxt;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  cur_id;
   logic [IW-1:0]  gnt_idx;
   logic [NREQ-1:0] grant;
   logic [2:0]     cnt;
   logic [WIDTH-1:0] cap_a, cap_b;
   logic [OPW-1:0] cap_op;
   logic           take;
   logic           exec_done;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   always_comb begin
      gnt_idx = '0;
      cap_a   = '0;
      cap_b   = '0;
      cap_op  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            gnt_idx = IW'(i);
            cap_a   = req_a[i*WIDTH +: WIDTH];
            cap_b   = req_b[i*WIDTH +: WIDTH];
            cap_op  = req_op[i*OPW +: OPW];
         end
      end
   end

   assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;
   assign take      = |(req_valid & req_ready);
   assign exec_done = (state == ST_EXEC) && (cnt == 3'd0);
   assign rsp_valid = (state == ST_RESP);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (take)      state_nxt = ST_EXEC;
         ST_EXEC: if (exec_done) state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= IW'(NREQ - 1);
         cur_id   <= '0;
         cnt      <= 3'd0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
      end else if (take) begin
         alu_a  <= cap_a;
         alu_b  <= cap_b;
         alu_op <= cap_op;
         cur_id <= gnt_idx;
         ptr    <= gnt_idx;
         cnt    <= 3'(ALU_LAT);
      end else if (state == ST_EXEC) begin
         // the extra cycle at zero is where alu_r gets sampled, giving
         // capture-to-response latency of ALU_LAT+1
         if (cnt == 3'd0) begin
            rsp_data <= alu_r;
            rsp_id   <= cur_id;
         end else begin
            cnt <= cnt - 3'd1;
         end
      end
   end

endmodule
